riscv_trace_buffer: RTL and testbench

//  Synthesisable retired-instruction trace buffer for the pipelined RISC-V core.

---
 rtl/riscv_trace_buffer_if.sv | 62 ++++++
 rtl/riscv_trace_buffer.sv | 178 +++++++++++++++++
 tb/tb_riscv_trace_buffer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_trace_buffer_if.sv
// -----------------------------------------------------------------------------
// riscv_trace_buffer_if
// Purpose : groups the capture, trigger, read-back and status signals of the
//           retired-instruction trace buffer into one bundle.
// Modports:
//   master - the core/debug side: drives retire, arm, trigger and read index,
//            observes read data and status.
//   slave  - the trace buffer itself.
// Signals :
//   valid_i, pc_i, instr_i     retire strobe and {pc, instr} of the instruction
//   arm_i                      clear buffer and start capture
//   trig_en_i, trig_pc_i       PC-match trigger enable and address
//   rd_addr_i                  read index, 0 = oldest captured entry
//   rd_pc_o, rd_instr_o        registered read data
//   rd_valid_o                 registered "index < count"
//   count_o, state_o, done_o   capture status
//   rd_ts_o                    registered timestamp (TRACE_TIMESTAMP_EN only)
// -----------------------------------------------------------------------------
interface riscv_trace_buffer_if #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
`ifdef TRACE_TIMESTAMP_EN
    ,
    parameter int TSW   = 16
`endif
);
    logic          valid_i;
    logic [DW-1:0] pc_i;
    logic [DW-1:0] instr_i;
    logic          arm_i;
    logic          trig_en_i;
    logic [DW-1:0] trig_pc_i;
    logic [AW-1:0] rd_addr_i;
    logic [DW-1:0] rd_pc_o;
    logic [DW-1:0] rd_instr_o;
    logic          rd_valid_o;
    logic [AW:0]   count_o;
    logic [1:0]    state_o;
    logic          done_o;
`ifdef TRACE_TIMESTAMP_EN
    logic [TSW-1:0] rd_ts_o;
`endif

    modport master (
        output valid_i, pc_i, instr_i, arm_i, trig_en_i, trig_pc_i, rd_addr_i,
        input  rd_pc_o, rd_instr_o, rd_valid_o, count_o, state_o, done_o
`ifdef TRACE_TIMESTAMP_EN
        ,
        input  rd_ts_o
`endif
    );

    modport slave (
        input  valid_i, pc_i, instr_i, arm_i, trig_en_i, trig_pc_i, rd_addr_i,
        output rd_pc_o, rd_instr_o, rd_valid_o, count_o, state_o, done_o
`ifdef TRACE_TIMESTAMP_EN
        ,
        output rd_ts_o
`endif
    );
endinterface

// File: rtl/riscv_trace_buffer.sv
// -----------------------------------------------------------------------------
// riscv_trace_buffer
// Purpose : captures {pc, instr} of every retired instruction into a DEPTH-entry
//           circular buffer. An optional PC-match trigger lets POST_TRIG more
//           entries be captured after the trigger entry, then the buffer
//           freezes so the history around the event can be read back
//           oldest-first by on-chip debug.
// Ports   :
//   clk_i  - clock
//   rst_i  - asynchronous reset, active-low
//   bus    - riscv_trace_buffer_if.slave (retire, arm, trigger, read, status)
// Config  : TRACE_TIMESTAMP_EN - adds a free-running TSW-bit cycle counter,
//           stores it with each entry and returns it on bus.rd_ts_o.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | out of reset, nothing captured
//   ARMED  | capturing every retire, watching for the trigger PC
//   POST   | trigger seen, capturing post_cnt more entries
//   FROZEN | capture stopped, contents stable for read-back
// -----------------------------------------------------------------------------
module riscv_trace_buffer #(
    parameter int DW        = 32,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int POST_TRIG = 4
`ifdef TRACE_TIMESTAMP_EN
    ,
    parameter int TSW       = 16
`endif
) (
    input logic                 clk_i,
    input logic                 rst_i,
    riscv_trace_buffer_if.slave bus
);

    localparam logic [1:0]    S_IDLE    = 2'd0;
    localparam logic [1:0]    S_ARMED   = 2'd1;
    localparam logic [1:0]    S_POST    = 2'd2;
    localparam logic [1:0]    S_FROZEN  = 2'd3;
    localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIG);
    localparam logic [AW-1:0] POST_LAST = AW'(1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_post_cnt;

    logic          w_capture;
    logic          w_trig;
    logic [AW-1:0] w_rd_base;
    logic [AW-1:0] w_rd_phys;

    logic [DW-1:0] r_mem_pc    [DEPTH];
    logic [DW-1:0] r_mem_instr [DEPTH];
    logic [DW-1:0] r_rd_pc;
    logic [DW-1:0] r_rd_instr;
    logic          r_rd_valid;

`ifdef TRACE_TIMESTAMP_EN
    logic [TSW-1:0] r_ts;
    logic [TSW-1:0] r_mem_ts [DEPTH];
    logic [TSW-1:0] r_rd_ts;
`endif

    // arm_i wins over a same-cycle retire: that instruction is dropped.
    assign w_capture = ((r_state == S_ARMED) || (r_state == S_POST)) &&
                       bus.valid_i && !bus.arm_i;
    assign w_trig    = (r_state == S_ARMED) && bus.valid_i && !bus.arm_i &&
                       bus.trig_en_i && (bus.pc_i == bus.trig_pc_i);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (bus.arm_i) begin
            w_state_nxt = S_ARMED;
        end else begin
            unique case (r_state)
                S_IDLE:   w_state_nxt = S_IDLE;
                S_ARMED:  if (w_trig) w_state_nxt = (POST_TRIG == 0) ? S_FROZEN : S_POST;
                S_POST:   if (bus.valid_i && (r_post_cnt == POST_LAST)) w_state_nxt = S_FROZEN;
                S_FROZEN: w_state_nxt = S_FROZEN;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.state_o = r_state;
        bus.done_o  = (r_state == S_FROZEN);
    end

    // ---------------- write pointer, fill count, post-trigger count ----------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
        end else if (bus.arm_i) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
        end else begin
            if (w_capture) begin
                // DEPTH is a power of two, so the pointer wraps on its own.
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_count != FULL) begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (w_trig) begin
                r_post_cnt <= POST_LOAD;
            end else if ((r_state == S_POST) && bus.valid_i) begin
                r_post_cnt <= r_post_cnt - 1'b1;
            end
        end
    end

    // ---------------- storage (not reset; rd_valid gates stale data) ----------------
    always_ff @(posedge clk_i) begin
        if (w_capture) begin
            r_mem_pc[r_wr_ptr]    <= bus.pc_i;
            r_mem_instr[r_wr_ptr] <= bus.instr_i;
`ifdef TRACE_TIMESTAMP_EN
            r_mem_ts[r_wr_ptr]    <= r_ts;
`endif
        end
    end

    // Once the buffer has wrapped, the oldest entry sits at the write pointer.
    assign w_rd_base = (r_count == FULL) ? r_wr_ptr : '0;
    assign w_rd_phys = w_rd_base + bus.rd_addr_i;

    // Registered read; a same-cycle write to that entry is seen next cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_pc    <= r_mem_pc[w_rd_phys];
            r_rd_instr <= r_mem_instr[w_rd_phys];
            r_rd_valid <= ({1'b0, bus.rd_addr_i} < r_count);
        end
    end

    assign bus.rd_pc_o    = r_rd_pc;
    assign bus.rd_instr_o = r_rd_instr;
    assign bus.rd_valid_o = r_rd_valid;
    assign bus.count_o    = r_count;

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ts    <= '0;
            r_rd_ts <= '0;
        end else begin
            r_ts    <= r_ts + 1'b1;
            r_rd_ts <= r_mem_ts[w_rd_phys];
        end
    end

    assign bus.rd_ts_o = r_rd_ts;
`endif

endmodule

// File: tb/tb_riscv_trace_buffer.sv
module tb_riscv_trace_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [DW-1:0] rd_pc;
    logic [DW-1:0] rd_ins;
    logic          rd_v;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]   rd_ts;
    logic [15:0]   ts0;
`endif

    always #5 clk = ~clk;

    riscv_trace_buffer_if #(.DW(DW), .DEPTH(DEPTH)) tb_if ();

    riscv_trace_buffer #(
        .DW(DW), .DEPTH(DEPTH), .POST_TRIG(4)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (tb_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc(input logic [31:0] pc);
        return pc ^ 32'h1234_5013;
    endfunction

    task automatic retire(input logic [31:0] pc);
        tb_if.valid_i = 1'b1;
        tb_if.pc_i    = pc;
        tb_if.instr_i = enc(pc);
        step();
        tb_if.valid_i = 1'b0;
    endtask

    task automatic arm();
        tb_if.arm_i = 1'b1;
        step();
        tb_if.arm_i = 1'b0;
    endtask

    task automatic rd(input int a);
        tb_if.rd_addr_i = AW'(a);
        step();
        rd_pc  = tb_if.rd_pc_o;
        rd_ins = tb_if.rd_instr_o;
        rd_v   = tb_if.rd_valid_o;
`ifdef TRACE_TIMESTAMP_EN
        rd_ts  = tb_if.rd_ts_o;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tb_if.valid_i   = 1'b0;
        tb_if.pc_i      = '0;
        tb_if.instr_i   = '0;
        tb_if.arm_i     = 1'b0;
        tb_if.trig_en_i = 1'b0;
        tb_if.trig_pc_i = '0;
        tb_if.rd_addr_i = '0;

        // reset values
        step();
        step();
        chk("rst_state",    64'(tb_if.state_o),    64'd0);
        chk("rst_count",    64'(tb_if.count_o),    64'd0);
        chk("rst_done",     64'(tb_if.done_o),     64'd0);
        chk("rst_rd_valid", 64'(tb_if.rd_valid_o), 64'd0);
        chk("rst_rd_pc",    64'(tb_if.rd_pc_o),    64'd0);
        rst = 1'b1;
        step();

        // IDLE ignores retires
        retire(32'h0000_0200);
        chk("idle_count", 64'(tb_if.count_o), 64'd0);

        // T1: five retires, no trigger
        arm();
        for (int k = 0; k < 5; k++) retire(32'(4 * k));
        chk("t1_count", 64'(tb_if.count_o), 64'd5);
        chk("t1_state", 64'(tb_if.state_o), 64'd1);
        for (int a = 0; a < 5; a++) begin
            rd(a);
            chk($sformatf("t1_pc%0d", a), 64'(rd_pc), 64'(4 * a));
            chk($sformatf("t1_v%0d", a),  64'(rd_v),  64'd1);
        end
        rd(1);
        chk("t1_instr1", 64'(rd_ins), 64'(enc(32'h4)));
        rd(5);
        chk("t1_v5", 64'(rd_v), 64'd0);

        // T2: wrap-around with 20 retires
        arm();
        for (int k = 0; k < 20; k++) retire(32'(4 * k));
        chk("t2_count", 64'(tb_if.count_o), 64'd16);
        rd(0);
        chk("t2_pc0", 64'(rd_pc), 64'h10);
        rd(15);
        chk("t2_pc15", 64'(rd_pc), 64'h4C);
        chk("t2_v15",  64'(rd_v),  64'd1);

        // T3: trigger at 0x20, four post-trigger entries
        arm();
        tb_if.trig_en_i = 1'b1;
        tb_if.trig_pc_i = 32'h20;
        for (int k = 0; k < 17; k++) begin
            retire(32'(4 * k));
            if (k == 8)  chk("t3_post",    64'(tb_if.state_o), 64'd2);
            if (k == 11) chk("t3_post_l",  64'(tb_if.state_o), 64'd2);
            if (k == 12) chk("t3_frozen",  64'(tb_if.state_o), 64'd3);
        end
        chk("t3_state", 64'(tb_if.state_o), 64'd3);
        chk("t3_done",  64'(tb_if.done_o),  64'd1);
        chk("t3_count", 64'(tb_if.count_o), 64'd13);
        rd(12);
        chk("t3_newest", 64'(rd_pc), 64'h30);
        rd(0);
        chk("t3_oldest", 64'(rd_pc), 64'h00);
        rd(13);
        chk("t3_v13", 64'(rd_v), 64'd0);
        tb_if.trig_en_i = 1'b0;

        // T4: arm and retire together, then one retire
        tb_if.arm_i   = 1'b1;
        tb_if.valid_i = 1'b1;
        tb_if.pc_i    = 32'h99;
        tb_if.instr_i = enc(32'h99);
        step();
        tb_if.arm_i   = 1'b0;
        tb_if.valid_i = 1'b0;
        chk("t4_count0", 64'(tb_if.count_o), 64'd0);
        chk("t4_state",  64'(tb_if.state_o), 64'd1);
        chk("t4_done",   64'(tb_if.done_o),  64'd0);
        retire(32'h80);
        chk("t4_count1", 64'(tb_if.count_o), 64'd1);
        rd(0);
        chk("t4_pc0", 64'(rd_pc), 64'h80);
        chk("t4_v0",  64'(rd_v),  64'd1);

        // T5: asynchronous reset while in POST with post_cnt == 2
        arm();
        tb_if.trig_en_i = 1'b1;
        tb_if.trig_pc_i = 32'h20;
        retire(32'h20);
        retire(32'h24);
        retire(32'h28);
        chk("t5_pre_state", 64'(tb_if.state_o), 64'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_state", 64'(tb_if.state_o), 64'd0);
        chk("t5_count", 64'(tb_if.count_o), 64'd0);
        chk("t5_done",  64'(tb_if.done_o),  64'd0);
        step();
        rst = 1'b1;
        tb_if.trig_en_i = 1'b0;
        step();
        arm();
        retire(32'h100);
        retire(32'h104);
        chk("t5_count2", 64'(tb_if.count_o), 64'd2);
        rd(1);
        chk("t5_pc1",    64'(rd_pc),  64'h104);
        chk("t5_instr1", 64'(rd_ins), 64'(enc(32'h104)));

`ifdef TRACE_TIMESTAMP_EN
        // T6: retires three cycles apart
        rst = 1'b0;
        step();
        rst = 1'b1;
        arm();
        retire(32'h300);
        step();
        step();
        retire(32'h304);
        rd(0);
        ts0 = rd_ts;
        rd(1);
        chk("t6_ts_delta", 64'(rd_ts - ts0), 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
